// File: rtl/sr_latch_without_enable.sv
// ---------------------------------------------------------------------------
// sr_latch_without_enable
//   Clocked model of a cross-coupled NOR SR latch with no enable input.
//   S sets, R resets, S=R=0 holds, S=R=1 drives Q=Q_not=0 and flags
//   'forbidden'. Leaving the forbidden state through 00 resolves to the
//   cleared state (Q=0, Q_not=1) so the model never oscillates.
//
//   SYNC_STAGES (0..3) optional synchronizer flops on S and R for inputs
//   coming from asynchronous sources; 0 samples S/R directly at the edge.
//   RESET_Q is the value Q takes on reset (Q_not takes its complement).
//
//   Optional feature macro: FORBIDDEN_COUNT_EN
//     Adds fcount[7:0] (saturating count of entries into forbidden) and
//     fsticky (set on any forbidden entry, cleared only by rst).
//
//   All outputs come straight from flops; rst is synchronous, active-high.
// ---------------------------------------------------------------------------
module sr_latch_without_enable #(
    parameter int   SYNC_STAGES = 0,
    parameter logic RESET_Q     = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       S,
    input  logic       R,
`ifdef FORBIDDEN_COUNT_EN
    output logic [7:0] fcount,
    output logic       fsticky,
`endif
    output logic       Q,
    output logic       Q_not,
    output logic       forbidden
);

    // Latch inputs as seen by the state logic (after any synchronizer).
    logic s_i;
    logic r_i;

    generate
        if (SYNC_STAGES == 0) begin : g_no_sync
            assign s_i = S;
            assign r_i = R;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] s_sync_d;
            logic [SYNC_STAGES-1:0] s_sync_q;
            logic [SYNC_STAGES-1:0] r_sync_d;
            logic [SYNC_STAGES-1:0] r_sync_q;

            // Shift S and R one stage deeper into their synchronizer chains.
            always_comb begin
                s_sync_d    = s_sync_q << 1;
                s_sync_d[0] = S;
                r_sync_d    = r_sync_q << 1;
                r_sync_d[0] = R;
            end

            // Synchronizer flops; cleared on reset so no stale request
            // survives a reset.
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge value of its neighbour; blocking
            // assignments here would collapse the chain into a single stage.
            always_ff @(posedge clk) begin
                if (rst) begin
                    s_sync_q <= '0;
                    r_sync_q <= '0;
                end else begin
                    s_sync_q <= s_sync_d;
                    r_sync_q <= r_sync_d;
                end
            end

            assign s_i = s_sync_q[SYNC_STAGES-1];
            assign r_i = r_sync_q[SYNC_STAGES-1];
        end
    endgenerate

    logic q_d;
    logic q_q;
    logic q_not_d;
    logic q_not_q;
    logic forbidden_d;
    logic forbidden_q;

    // Next latch state from the decoded {s_i, r_i} request.
    // NOTE: every output of this block is given a default first (hold), so
    // no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        q_d         = q_q;
        q_not_d     = q_not_q;
        forbidden_d = forbidden_q;
        case ({s_i, r_i})
            2'b10: begin
                q_d         = 1'b1;
                q_not_d     = 1'b0;
                forbidden_d = 1'b0;
            end
            2'b01: begin
                q_d         = 1'b0;
                q_not_d     = 1'b1;
                forbidden_d = 1'b0;
            end
            2'b11: begin
                q_d         = 1'b0;
                q_not_d     = 1'b0;
                forbidden_d = 1'b1;
            end
            default: begin
                // 00, or X/Z on either input: hold, except that the
                // forbidden state resolves deterministically to cleared.
                if (forbidden_q) begin
                    q_d         = 1'b0;
                    q_not_d     = 1'b1;
                    forbidden_d = 1'b0;
                end
            end
        endcase
    end

    // Latch state register; reset wins over any S/R request on that edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q         <= RESET_Q;
            q_not_q     <= ~RESET_Q;
            forbidden_q <= 1'b0;
        end else begin
            q_q         <= q_d;
            q_not_q     <= q_not_d;
            forbidden_q <= forbidden_d;
        end
    end

    assign Q         = q_q;
    assign Q_not     = q_not_q;
    assign forbidden = forbidden_q;

`ifdef FORBIDDEN_COUNT_EN
    logic [7:0] fcount_d;
    logic [7:0] fcount_q;
    logic       fsticky_d;
    logic       fsticky_q;
    logic       forbidden_entry;

    // Count and remember entries into the forbidden state (0->1 edges).
    always_comb begin
        forbidden_entry = forbidden_d & ~forbidden_q;
        fcount_d        = fcount_q;
        fsticky_d       = fsticky_q;
        if (forbidden_entry) begin
            fsticky_d = 1'b1;
            if (fcount_q != 8'hFF) begin
                fcount_d = fcount_q + 8'd1;
            end
        end
    end

    // Forbidden-entry statistics registers; cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            fcount_q  <= 8'd0;
            fsticky_q <= 1'b0;
        end else begin
            fcount_q  <= fcount_d;
            fsticky_q <= fsticky_d;
        end
    end

    assign fcount  = fcount_q;
    assign fsticky = fsticky_q;
`endif

endmodule

// File: tb/tb_sr_latch_without_enable.sv
// ---------------------------------------------------------------------------
// tb_sr_latch_without_enable
//   Scoreboard bench for sr_latch_without_enable. Two instances share the
//   same stimulus: one with SYNC_STAGES=0 and one with SYNC_STAGES=2.
//   The driver computes the expected outputs from a behavioural model
//   (a three-valued latch state plus a delay line for the synchronizer)
//   and pushes them into queues; a monitor pops and compares them one
//   time unit after every rising edge that applied a stimulus.
//   Fault-counting checks are compiled in with FORBIDDEN_COUNT_EN.
// ---------------------------------------------------------------------------
module tb_sr_latch_without_enable;

    localparam int   N_MODELS = 2;
    localparam logic RESET_Q  = 1'b0;

    typedef enum int { ST_SET, ST_CLR, ST_FORB } lat_st_t;

    typedef struct packed {
        logic       q;
        logic       qn;
        logic       f;
        logic [7:0] cnt;
        logic       sticky;
    } exp_t;

    logic clk;
    logic rst;
    logic S;
    logic R;

    logic q0, qn0, f0;
    logic q2, qn2, f2;
`ifdef FORBIDDEN_COUNT_EN
    logic [7:0] cnt0, cnt2;
    logic       st0, st2;
`endif

    sr_latch_without_enable #(.SYNC_STAGES(0), .RESET_Q(RESET_Q)) dut (
        .clk       (clk),
        .rst       (rst),
        .S         (S),
        .R         (R),
`ifdef FORBIDDEN_COUNT_EN
        .fcount    (cnt0),
        .fsticky   (st0),
`endif
        .Q         (q0),
        .Q_not     (qn0),
        .forbidden (f0)
    );

    sr_latch_without_enable #(.SYNC_STAGES(2), .RESET_Q(RESET_Q)) dut_sync (
        .clk       (clk),
        .rst       (rst),
        .S         (S),
        .R         (R),
`ifdef FORBIDDEN_COUNT_EN
        .fcount    (cnt2),
        .fsticky   (st2),
`endif
        .Q         (q2),
        .Q_not     (qn2),
        .forbidden (f2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    exp_t exp_q0[$];
    exp_t exp_q2[$];

    // ---------------- behavioural model ----------------
    int      latency  [N_MODELS];
    lat_st_t m_state  [N_MODELS];
    int      m_cnt    [N_MODELS];
    bit      m_sticky [N_MODELS];
    bit      dl_s     [N_MODELS][$];
    bit      dl_r     [N_MODELS][$];

    function automatic exp_t model_step(int m, bit r_st, bit s, bit r);
        exp_t e;
        bit es, er;
        if (r_st) begin
            m_state[m]  = RESET_Q ? ST_SET : ST_CLR;
            m_cnt[m]    = 0;
            m_sticky[m] = 0;
            dl_s[m].delete();
            dl_r[m].delete();
            for (int i = 0; i < latency[m]; i++) begin
                dl_s[m].push_back(1'b0);
                dl_r[m].push_back(1'b0);
            end
        end else begin
            if (latency[m] == 0) begin
                es = s;
                er = r;
            end else begin
                dl_s[m].push_back(s);
                dl_r[m].push_back(r);
                es = dl_s[m].pop_front();
                er = dl_r[m].pop_front();
            end
            if (es && er) begin
                if (m_state[m] != ST_FORB) begin
                    m_sticky[m] = 1;
                    if (m_cnt[m] < 255) m_cnt[m]++;
                end
                m_state[m] = ST_FORB;
            end else if (es) begin
                m_state[m] = ST_SET;
            end else if (er) begin
                m_state[m] = ST_CLR;
            end else if (m_state[m] == ST_FORB) begin
                m_state[m] = ST_CLR;
            end
        end
        e.q      = (m_state[m] == ST_SET);
        e.qn     = (m_state[m] == ST_CLR);
        e.f      = (m_state[m] == ST_FORB);
        e.cnt    = 8'(m_cnt[m]);
        e.sticky = m_sticky[m];
        return e;
    endfunction

    // ---------------- driver ----------------
    task automatic step(input bit r_st, input bit s, input bit r);
        @(negedge clk);
        rst = r_st;
        S   = s;
        R   = r;
        exp_q0.push_back(model_step(0, r_st, s, r));
        exp_q2.push_back(model_step(1, r_st, s, r));
    endtask

    task automatic hold(input bit s, input bit r, input int n);
        for (int i = 0; i < n; i++) step(1'b0, s, r);
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q0.size() > 0) begin
                e = exp_q0.pop_front();
                check("s0_q",         int'(q0),  int'(e.q));
                check("s0_q_not",     int'(qn0), int'(e.qn));
                check("s0_forbidden", int'(f0),  int'(e.f));
`ifdef FORBIDDEN_COUNT_EN
                check("s0_fcount",    int'(cnt0), int'(e.cnt));
                check("s0_fsticky",   int'(st0),  int'(e.sticky));
`endif
            end
            if (exp_q2.size() > 0) begin
                e = exp_q2.pop_front();
                check("s2_q",         int'(q2),  int'(e.q));
                check("s2_q_not",     int'(qn2), int'(e.qn));
                check("s2_forbidden", int'(f2),  int'(e.f));
`ifdef FORBIDDEN_COUNT_EN
                check("s2_fcount",    int'(cnt2), int'(e.cnt));
                check("s2_fsticky",   int'(st2),  int'(e.sticky));
`endif
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin : stimulus
        int budget;
        int sel;
        latency[0] = 0;
        latency[1] = 2;
        rst = 1'b0;
        S   = 1'b0;
        R   = 1'b0;

        // Reset, then the directed sequences.
        step(1'b1, 1'b0, 1'b0);
        hold(1'b1, 1'b0, 20);       // set for 200ns
        hold(1'b0, 1'b0, 20);       // hold set
        hold(1'b0, 1'b1, 5);        // reset
        hold(1'b0, 1'b0, 5);        // hold reset
        hold(1'b1, 1'b1, 5);        // forbidden
        hold(1'b0, 1'b0, 5);        // leave forbidden via 00
        hold(1'b1, 1'b1, 3);        // forbidden again
        hold(1'b1, 1'b0, 4);        // leave via set
        hold(1'b1, 1'b1, 3);
        hold(1'b0, 1'b1, 4);        // leave via reset
        step(1'b0, 1'b1, 1'b0);     // single-cycle S pulse
        hold(1'b0, 1'b0, 6);
        hold(1'b1, 1'b0, 4);
        step(1'b1, 1'b1, 1'b0);     // reset concurrent with S
        hold(1'b0, 1'b0, 4);
        hold(1'b1, 1'b0, 1);        // S in flight in the synchronizer ...
        step(1'b1, 1'b0, 1'b0);     // ... is discarded by reset
        hold(1'b0, 1'b0, 4);

        // Many forbidden entries to push the counter towards saturation.
        for (int i = 0; i < 260; i++) begin
            step(1'b0, 1'b1, 1'b1);
            step(1'b0, 1'b0, 1'b0);
        end
        hold(1'b0, 1'b0, 4);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            sel = int'($urandom_range(0, 39));
            if (sel == 0) step(1'b1, 1'($urandom), 1'($urandom));
            else          step(1'b0, 1'($urandom), 1'($urandom));
        end
        hold(1'b0, 1'b0, 4);

        // Let the monitor drain the scoreboard, bounded.
        budget = 0;
        while ((exp_q0.size() > 0 || exp_q2.size() > 0) && budget < 10) begin
            @(posedge clk);
            budget++;
        end
        @(negedge clk);
        checks++;
        if (exp_q0.size() > 0 || exp_q2.size() > 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d/%0d pending expected 0/0",
                     exp_q0.size(), exp_q2.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
